// File: rtl/digit_sprite_reader_if.sv
// Signal bundle between the scan/placement source, the digit sprite reader,
// the sprite ROM and the pixel mux. "slave" is the reader's view; "master"
// is the view of whatever drives the scan and placement and hosts the ROM.
interface digit_sprite_reader_if #(
  parameter int COORD_W = 10
);
  // placement requests, latched into the reader at frame start
  logic               frame_start;
  logic [COORD_W-1:0] pos_x_in;
  logic [COORD_W-1:0] pos_y_in;
  logic [1:0]         scale_in;
  logic               enable_in;
  // scan position
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic               video_on;
  // ROM read bus
  logic [4:0]         rom_row;
  logic [4:0]         rom_col;
  logic [11:0]        rom_data;
  // aligned pixel output
  logic [11:0]        pixel_color;
  logic               pixel_hit;
  logic               pixel_valid;

  modport slave (
    input  frame_start, pos_x_in, pos_y_in, scale_in, enable_in,
    input  pixel_x, pixel_y, video_on, rom_data,
    output rom_row, rom_col, pixel_color, pixel_hit, pixel_valid
  );

  modport master (
    output frame_start, pos_x_in, pos_y_in, scale_in, enable_in,
    output pixel_x, pixel_y, video_on, rom_data,
    input  rom_row, rom_col, pixel_color, pixel_hit, pixel_valid
  );
endinterface

// File: rtl/digit_sprite_reader.sv
// Digit sprite reader: turns the scan position into registered ROM row/col
// addresses for a synchronous sprite ROM, then re-aligns the returned colour
// with a delayed hit/valid pipeline. Placement is double-buffered and only
// swaps at frame start so a sprite never tears mid-frame.
module digit_sprite_reader #(
  parameter int          SPRITE_W     = 25,
  parameter int          SPRITE_H     = 30,
  parameter int          COORD_W      = 10,
  parameter int          ROM_LAT      = 1,
  parameter bit          TRANSP_EN    = 1'b1,
  parameter logic [11:0] TRANSP_COLOR = 12'hFFF
) (
  input logic                   clk,
  input logic                   rst_n,
  digit_sprite_reader_if.slave  bus
);

  localparam int XW = COORD_W + 1;
  typedef logic [XW-1:0] ext_t;

  // active (shadow) placement
  logic [COORD_W-1:0] act_x_q, act_y_q;
  logic [1:0]         act_scale_q;
  logic               act_en_q;

  // stage A
  ext_t               dx, dy, w_lim, h_lim;
  logic               in_box;
  logic [4:0]         row_d, col_d;
  logic [4:0]         rom_row_q, rom_col_q;

  // hit/valid delay line: index 0 is stage A, index ROM_LAT lines up with rom_data
  logic [ROM_LAT:0]   hit_pipe_q, vld_pipe_q;

  // stage B
  logic               transp, hit_d;
  logic [11:0]        color_d;
  logic [11:0]        pixel_color_q;
  logic               pixel_hit_q, pixel_valid_q;

  // Latch requested placement at frame start; scale 3 clamps to x4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_x_q     <= '0;
      act_y_q     <= '0;
      act_scale_q <= '0;
      act_en_q    <= 1'b0;
    end else if (bus.frame_start) begin
      act_x_q     <= bus.pos_x_in;
      act_y_q     <= bus.pos_y_in;
      act_scale_q <= (bus.scale_in == 2'd3) ? 2'd2 : bus.scale_in;
      act_en_q    <= bus.enable_in;
    end
  end

  // Box test at COORD_W+1 bits; the explicit >= guards make any underflow a miss.
  always_comb begin
    dx     = {1'b0, bus.pixel_x} - {1'b0, act_x_q};
    dy     = {1'b0, bus.pixel_y} - {1'b0, act_y_q};
    w_lim  = ext_t'(SPRITE_W) << act_scale_q;
    h_lim  = ext_t'(SPRITE_H) << act_scale_q;
    in_box = bus.video_on & act_en_q &
             (bus.pixel_x >= act_x_q) & (bus.pixel_y >= act_y_q) &
             (dx < w_lim) & (dy < h_lim);
    col_d  = in_box ? 5'(dx >> act_scale_q) : 5'd0;
    row_d  = in_box ? 5'(dy >> act_scale_q) : 5'd0;
  end

  // Stage A registers: ROM address plus the head of the hit/valid delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_row_q  <= '0;
      rom_col_q  <= '0;
      hit_pipe_q <= '0;
      vld_pipe_q <= '0;
    end else begin
      rom_row_q  <= row_d;
      rom_col_q  <= col_d;
      hit_pipe_q <= {hit_pipe_q[ROM_LAT-1:0], in_box};
      vld_pipe_q <= {vld_pipe_q[ROM_LAT-1:0], bus.video_on};
    end
  end

  // Key-colour pixels read as background; colour is forced to 0 on a miss.
  always_comb begin
    transp  = TRANSP_EN && (bus.rom_data == TRANSP_COLOR);
    hit_d   = hit_pipe_q[ROM_LAT] & ~transp;
    color_d = hit_d ? bus.rom_data : 12'h000;
  end

  // Stage B output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_color_q <= '0;
      pixel_hit_q   <= 1'b0;
      pixel_valid_q <= 1'b0;
    end else begin
      pixel_color_q <= color_d;
      pixel_hit_q   <= hit_d;
      pixel_valid_q <= vld_pipe_q[ROM_LAT];
    end
  end

  assign bus.rom_row     = rom_row_q;
  assign bus.rom_col     = rom_col_q;
  assign bus.pixel_color = pixel_color_q;
  assign bus.pixel_hit   = pixel_hit_q;
  assign bus.pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_digit_sprite_reader.sv
// Bench for digit_sprite_reader: two instances (key colour on / off) share
// the same stimulus and each reads its own 1-clock ROM. A cycle-level model
// computes each pixel's expected output from the box rules with plain
// integer arithmetic and delays it by two edges.
module tb_digit_sprite_reader;

  logic       clk, rst_n;
  logic       fs, en, vo;
  logic [9:0] posx, posy, px, py;
  logic [1:0] sc;

  digit_sprite_reader_if #(.COORD_W(10)) ifT ();
  digit_sprite_reader_if #(.COORD_W(10)) ifN ();

  assign ifT.frame_start = fs;   assign ifN.frame_start = fs;
  assign ifT.pos_x_in    = posx; assign ifN.pos_x_in    = posx;
  assign ifT.pos_y_in    = posy; assign ifN.pos_y_in    = posy;
  assign ifT.scale_in    = sc;   assign ifN.scale_in    = sc;
  assign ifT.enable_in   = en;   assign ifN.enable_in   = en;
  assign ifT.pixel_x     = px;   assign ifN.pixel_x     = px;
  assign ifT.pixel_y     = py;   assign ifN.pixel_y     = py;
  assign ifT.video_on    = vo;   assign ifN.video_on    = vo;

  digit_sprite_reader dutT (.clk(clk), .rst_n(rst_n), .bus(ifT));
  digit_sprite_reader #(.TRANSP_EN(1'b0)) dutN (.clk(clk), .rst_n(rst_n), .bus(ifN));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // sprite content: (5,5) is the key colour, everything else encodes row/col
  function automatic logic [11:0] rom_fn(int r, int c);
    if (r == 5 && c == 5) return 12'hFFF;
    return {2'b00, 5'(r), 5'(c)};
  endfunction

  always @(posedge clk) ifT.rom_data <= rom_fn(int'(ifT.rom_row), int'(ifT.rom_col));
  always @(posedge clk) ifN.rom_data <= rom_fn(int'(ifN.rom_row), int'(ifN.rom_col));

  // ---------------- reference model ----------------
  typedef struct {
    bit          hit_t;
    logic [11:0] col_t;
    bit          hit_n;
    logic [11:0] col_n;
    bit          vld;
  } exp_t;

  int   m_ax, m_ay, m_sc;
  bit   m_en;
  int   m_row, m_col;
  exp_t e0, e1, eo;
  int   n_chk, n_err;

  function automatic exp_t zero_exp();
    exp_t z;
    z.hit_t = 0; z.col_t = '0; z.hit_n = 0; z.col_n = '0; z.vld = 0;
    return z;
  endfunction

  task automatic model_reset();
    m_ax = 0; m_ay = 0; m_sc = 0; m_en = 0;
    m_row = 0; m_col = 0;
    e0 = zero_exp(); e1 = zero_exp(); eo = zero_exp();
  endtask

  // one rising edge as seen from the outside: sample pixel, advance delays, load placement
  task automatic model_edge();
    int dx, dy, mult, r, c;
    bit inb;
    logic [11:0] colr;
    exp_t n;
    mult = 1 << m_sc;
    dx   = int'(px) - m_ax;
    dy   = int'(py) - m_ay;
    inb  = vo && m_en && dx >= 0 && dy >= 0 && dx < 25 * mult && dy < 30 * mult;
    r    = inb ? dy / mult : 0;
    c    = inb ? dx / mult : 0;
    colr = rom_fn(r, c);
    n.hit_t = inb && colr != 12'hFFF;
    n.col_t = n.hit_t ? colr : 12'h000;
    n.hit_n = inb;
    n.col_n = inb ? colr : 12'h000;
    n.vld   = vo;
    eo = e1; e1 = e0; e0 = n;
    m_row = r; m_col = c;
    if (fs) begin
      m_ax = int'(posx); m_ay = int'(posy);
      m_sc = (sc > 2) ? 2 : int'(sc);
      m_en = en;
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("rom_row",   int'(ifT.rom_row),     m_row);
    chk("rom_col",   int'(ifT.rom_col),     m_col);
    chk("hit_T",     int'(ifT.pixel_hit),   int'(eo.hit_t));
    chk("color_T",   int'(ifT.pixel_color), int'(eo.col_t));
    chk("valid_T",   int'(ifT.pixel_valid), int'(eo.vld));
    chk("rom_row_N", int'(ifN.rom_row),     m_row);
    chk("rom_col_N", int'(ifN.rom_col),     m_col);
    chk("hit_N",     int'(ifN.pixel_hit),   int'(eo.hit_n));
    chk("color_N",   int'(ifN.pixel_color), int'(eo.col_n));
    chk("valid_N",   int'(ifN.pixel_valid), int'(eo.vld));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit fs;
    int posx, posy, sc, en;
    int px, py;
    int row, col;
    int hit_t, col_t, hit_n, col_n;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1, 100, 50, 0, 1,  100,  50,  0,  0, 1, 'h000, 1, 'h000};
    vecs[1]  = '{0, 100, 50, 0, 1,  124,  79, 29, 24, 1, 'h3B8, 1, 'h3B8};
    vecs[2]  = '{0, 100, 50, 0, 1,  125,  50,  0,  0, 0, 'h000, 0, 'h000};
    vecs[3]  = '{0, 100, 50, 0, 1,  100,  80,  0,  0, 0, 'h000, 0, 'h000};
    vecs[4]  = '{0, 100, 50, 0, 1,   99,  50,  0,  0, 0, 'h000, 0, 'h000};
    vecs[5]  = '{1, 100, 50, 1, 1,  149, 109, 29, 24, 1, 'h3B8, 1, 'h3B8};
    vecs[6]  = '{0, 100, 50, 1, 1,  150,  50,  0,  0, 0, 'h000, 0, 'h000};
    vecs[7]  = '{1, 100, 50, 3, 1,  199, 169, 29, 24, 1, 'h3B8, 1, 'h3B8};
    vecs[8]  = '{1, 100, 50, 0, 1,  105,  55,  5,  5, 0, 'h000, 1, 'hFFF};
    vecs[9]  = '{0, 300, 50, 0, 1,  100,  50,  0,  0, 1, 'h000, 1, 'h000};
    vecs[10] = '{1, 300, 50, 0, 1,  100,  50,  0,  0, 0, 'h000, 0, 'h000};
    vecs[11] = '{0, 300, 50, 0, 1,  300,  50,  0,  0, 1, 'h000, 1, 'h000};
    vecs[12] = '{1, 1010, 50, 0, 1,   5,  50,  0,  0, 0, 'h000, 0, 'h000};
    vecs[13] = '{0, 1010, 50, 0, 1, 1012, 52,  2,  2, 1, 'h042, 1, 'h042};

    n_chk = 0; n_err = 0;
    rst_n = 1'b0;
    fs = 0; en = 0; vo = 0; sc = '0;
    posx = '0; posy = '0; px = '0; py = '0;
    model_reset();
    #1;
    chk("reset_hit",   int'(ifT.pixel_hit),   0);
    chk("reset_valid", int'(ifT.pixel_valid), 0);
    chk("reset_color", int'(ifT.pixel_color), 0);
    chk("reset_row",   int'(ifT.rom_row),     0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cycle();

    // directed table
    foreach (vecs[i]) begin
      posx = 10'(vecs[i].posx); posy = 10'(vecs[i].posy);
      sc = 2'(vecs[i].sc); en = vecs[i].en[0];
      fs = vecs[i].fs; vo = 0;
      cycle();
      fs = 0;
      px = 10'(vecs[i].px); py = 10'(vecs[i].py); vo = 1;
      cycle();
      chk($sformatf("v%0d_row", i), int'(ifT.rom_row), vecs[i].row);
      chk($sformatf("v%0d_col", i), int'(ifT.rom_col), vecs[i].col);
      vo = 0;
      cycle();
      cycle();
      chk($sformatf("v%0d_hitT", i), int'(ifT.pixel_hit),   vecs[i].hit_t);
      chk($sformatf("v%0d_colT", i), int'(ifT.pixel_color), vecs[i].col_t);
      chk($sformatf("v%0d_hitN", i), int'(ifN.pixel_hit),   vecs[i].hit_n);
      chk($sformatf("v%0d_colN", i), int'(ifN.pixel_color), vecs[i].col_n);
    end

    // reset with hits in flight
    posx = 10'd100; posy = 10'd50; sc = 2'd0; en = 1; fs = 1; vo = 0;
    cycle();
    fs = 0; vo = 1; px = 10'd110; py = 10'd60;
    repeat (3) cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_hit",   int'(ifT.pixel_hit),   0);
    chk("mid_rst_valid", int'(ifT.pixel_valid), 0);
    chk("mid_rst_color", int'(ifT.pixel_color), 0);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk($sformatf("post_rst%0d_hit", k),   int'(ifT.pixel_hit),   0);
      chk($sformatf("post_rst%0d_valid", k), int'(ifT.pixel_valid), 0);
      chk($sformatf("post_rst%0d_color", k), int'(ifT.pixel_color), 0);
    end
    repeat (3) cycle();
    chk("post_rst_en_off", int'(ifT.pixel_hit), 0);
    chk("post_rst_valid",  int'(ifT.pixel_valid), 1);

    // randomized scan checked against the model every cycle
    for (int k = 0; k < 3000; k++) begin
      fs   = ($urandom_range(0, 7) == 0);
      posx = 10'($urandom_range(0, 1023));
      posy = 10'($urandom_range(0, 1023));
      sc   = 2'($urandom_range(0, 3));
      en   = ($urandom_range(0, 5) != 0);
      vo   = ($urandom_range(0, 7) != 0);
      px   = 10'(m_ax + int'($urandom_range(0, 110)) - 5);
      py   = 10'(m_ay + int'($urandom_range(0, 130)) - 5);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/digit_sprite_reader.md
Name: digit_sprite_reader

Overview:
- Read-side client for the 25x30 digit sprite ROMs: the ROMs take row/col and return 12-bit colour one clock later.
- Takes the VGA scan position and the sprite's on-screen placement, and drives registered row/col addresses to a synchronous ROM.
- Aligns the returned colour with a delayed hit/valid pipeline and presents per-pixel colour plus a draw flag to the pixel mux.
- Placement (position, scale, enable) is double-buffered and swaps only at frame start, so a sprite never tears mid-frame.

Parameters:
- SPRITE_W, 25, sprite width in pixels (col range 0..SPRITE_W-1).
- SPRITE_H, 30, sprite height in pixels (row range 0..SPRITE_H-1).
- COORD_W, 10, width of screen coordinates.
- ROM_LAT, 1, ROM read latency in clocks; legal values 1..3.
- TRANSP_EN, 1, 1 = pixels equal to TRANSP_COLOR are not drawn.
- TRANSP_COLOR, 12'hFFF, key colour treated as background.

Ports:
- clk  in  1  system/pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start of each frame; loads the shadow placement registers.
- pos_x_in  in  COORD_W  requested sprite left edge.
- pos_y_in  in  COORD_W  requested sprite top edge.
- scale_in  in  2  integer scale as a shift: 0 = x1, 1 = x2, 2 = x4; 3 is clamped to 2.
- enable_in  in  1  requested sprite visibility.
- pixel_x  in  COORD_W  current scan column.
- pixel_y  in  COORD_W  current scan row.
- video_on  in  1  scan position is in the visible area.
- rom_data  in  12  colour returned by the digit ROM.
- rom_row  out  5  ROM row address (registered).
- rom_col  out  5  ROM column address (registered).
- pixel_color  out  12  colour of the aligned pixel; 12'h000 when pixel_hit = 0.
- pixel_hit  out  1  sprite draws this pixel.
- pixel_valid  out  1  delayed video_on, aligned with pixel_color.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; active_x = 0, active_y = 0, active_scale = 0, active_en = 0; pipeline hit/valid bits cleared. Reset mid-frame discards all in-flight pixels.
- Shadow load: at a clock edge with frame_start = 1, active_* <= *_in (scale clamped). The pixel sampled at that same edge still uses the old active_* values.
- Stage A, edge k (samples pixel_x, pixel_y, video_on):
  - dx = pixel_x - active_x and dy = pixel_y - active_y, computed at COORD_W+1 bits.
  - in_box = video_on & active_en & pixel_x >= active_x & pixel_y >= active_y & dx < (SPRITE_W << active_scale) & dy < (SPRITE_H << active_scale).
  - If in_box: rom_col <= dx >> active_scale, rom_row <= dy >> active_scale. Otherwise rom_row <= 0, rom_col <= 0.
  - hit_a <= in_box, valid_a <= video_on.
- Delay line: hit_a/valid_a travel through ROM_LAT registers, so they align with rom_data after edge k+ROM_LAT.
- Stage B, edge k+ROM_LAT+1:
  - pixel_hit <= hit_d & ~(TRANSP_EN & rom_data == TRANSP_COLOR).
  - pixel_color <= rom_data when that hit is set, else 12'h000.
  - pixel_valid <= valid_d.
- Latency: fixed ROM_LAT+1 edges from pixel sample to output, i.e. 2 for the default. Throughput is one pixel per clock with no stalls.
- No coordinate wrap: a sprite partially off the right or bottom edge is clipped. Subtraction underflow is a miss and is never wrapped into a hit.
- Right/bottom bound is exclusive: the last drawn column is active_x + (SPRITE_W << scale) - 1.
- frame_start and in-box pixels on the same edge are legal; the new placement applies from the next edge.
- The pipeline keeps running while video_on = 0; hit is forced to 0.

Test Plan:
- Reset, pos (100,50), scale 0, enable 1, frame_start pulse. Scan pixel (100,50) at edge k → rom_row = 0, rom_col = 0 after edge k. With rom_data = 12'h000 at edge k+1, pixel_hit = 1 and pixel_color = 000 after edge k+2.
- Same placement, pixel (124,79) → row 29, col 24, hit. Pixels (125,50), (100,80) and (99,50) → pixel_hit = 0, rom_row/col = 0.
- Scale 1 at pos (100,50): pixel (149,109) → row 29, col 24, hit. Pixel (150,50) → miss. Scale_in = 3 behaves as scale 2: pixel (199,169) → row 29, col 24, hit.
- Transparency: in-box pixel with rom_data = 12'hFFF → pixel_hit = 0, color 000. Same pixel with TRANSP_EN = 0 → pixel_hit = 1, color FFF.
- Placement change: pos_x_in = 300 presented mid-frame without frame_start → pixel (100,50) still hits. After a frame_start edge, (100,50) misses and (300,50) hits. pos_x = 1010 with pixel_x = 5 → miss (no wrap).
- Assert rst_n low for 1 cycle while hits are in flight → pixel_hit, pixel_valid and pixel_color are 0 immediately and on the next 2 edges. active_en = 0 until the next frame_start.
